md_unit: RTL

Iterative multiply/divide unit in the EX stage. It computes MULT/MULTU/DIV/DIVU into the architectural HI/LO registers and also serves MTHI/MTLO writes. While a multi-cycle operation runs it drives `stall_o`; that signal feeds the `hold_i` of the IF/ID, ID/EX and EX/MEM pipeline registers, which freeze the pipeline until HI/LO are valid.

---
 rtl/md_unit_if.sv | 31 +++
 rtl/md_unit.sv | 134 +++++++++++++
 2 files changed

// File: rtl/md_unit_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | md_unit_if : EX-stage <-> multiply/divide unit signal bundle      |
// | Revision   : 1.0                                                  |
// +------------------------------------------------------------------+
interface md_unit_if #(
    parameter int WIDTH = 32
);
    logic             start_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             hi_we_i;
    logic             lo_we_i;
    logic [WIDTH-1:0] wdata_i;
    logic             stall_o;
    logic             done_o;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start_i, op_i, a_i, b_i, hi_we_i, lo_we_i, wdata_i,
        input  stall_o, done_o, hi_o, lo_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, hi_we_i, lo_we_i, wdata_i,
        output stall_o, done_o, hi_o, lo_o
    );
endinterface
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | md_unit  : iterative MULT/MULTU/DIV/DIVU unit owning HI/LO        |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
module md_unit #(
    parameter int WIDTH = 32
) (
    input  wire logic  clk_i,
    input  wire logic  rst_i,
    md_unit_if.slave   md
);
    localparam int c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                 r_state;
    logic [2*WIDTH-1:0]     r_acc;
    logic [WIDTH-1:0]       r_opb;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_sa;
    logic                   r_sb;
    logic                   r_is_div;
    logic [WIDTH-1:0]       r_hi;
    logic [WIDTH-1:0]       r_lo;
    logic                   r_done;

    logic                   w_div0;
    logic                   w_neg_a;
    logic                   w_neg_b;
    logic [WIDTH-1:0]       w_mag_a;
    logic [WIDTH-1:0]       w_mag_b;
    logic [WIDTH:0]         w_addend;
    logic [WIDTH:0]         w_add;
    logic [2*WIDTH-1:0]     w_mul_next;
    logic [WIDTH:0]         w_shift;
    logic [WIDTH:0]         w_trial;
    logic [2*WIDTH-1:0]     w_div_next;
    logic [2*WIDTH-1:0]     w_prod;
    logic [WIDTH-1:0]       w_quo;
    logic [WIDTH-1:0]       w_rem;
    logic [WIDTH-1:0]       w_fix_hi;
    logic [WIDTH-1:0]       w_fix_lo;

    assign w_div0  = md.op_i[1] & (md.b_i == '0);
    assign w_neg_a = md.op_i[0] & md.a_i[WIDTH-1];
    assign w_neg_b = md.op_i[0] & md.b_i[WIDTH-1];
    // Magnitudes stay WIDTH bits: the most negative value maps to unsigned 2^(WIDTH-1).
    assign w_mag_a = w_neg_a ? -md.a_i : md.a_i;
    assign w_mag_b = w_neg_b ? -md.b_i : md.b_i;

    // Multiply: upper half accumulates, the multiplier drains out of the lower half.
    assign w_addend   = r_acc[0] ? {1'b0, r_opb} : '0;
    assign w_add      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + w_addend;
    assign w_mul_next = {w_add, r_acc[WIDTH-1:1]};

    // Divide: upper half is the partial remainder, lower half shifts dividend out / quotient in.
    assign w_shift    = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_trial    = w_shift - {1'b0, r_opb};
    assign w_div_next = w_trial[WIDTH] ? {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                       : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    assign w_prod   = (r_sa ^ r_sb) ? -r_acc : r_acc;
    assign w_quo    = (r_sa ^ r_sb) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem    = r_sa ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    assign w_fix_hi = r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
    assign w_fix_lo = r_is_div ? w_quo : w_prod[WIDTH-1:0];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_opb    <= '0;
            r_cnt    <= '0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_is_div <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (md.start_i) begin
                        if (w_div0) begin
                            r_hi <= md.a_i;
                            r_lo <= '1;
                        end else begin
                            r_sa     <= w_neg_a;
                            r_sb     <= w_neg_b;
                            r_is_div <= md.op_i[1];
                            r_opb    <= md.op_i[1] ? w_mag_b : w_mag_a;
                            r_acc    <= {{WIDTH{1'b0}}, (md.op_i[1] ? w_mag_a : w_mag_b)};
                            r_cnt    <= '0;
                            r_state  <= S_RUN;
                        end
                    end else begin
                        if (md.hi_we_i) r_hi <= md.wdata_i;
                        if (md.lo_we_i) r_lo <= md.wdata_i;
                    end
                end
                S_RUN: begin
                    r_acc <= r_is_div ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) r_state <= S_FIX;
                end
                S_FIX: begin
                    r_hi    <= w_fix_hi;
                    r_lo    <= w_fix_lo;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                // start_i here still belongs to the instruction that just finished.
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Combinational so the hold takes effect in the start cycle itself.
    assign md.stall_o = rst_i & (((r_state == S_IDLE) & md.start_i & ~w_div0) |
                                 (r_state == S_RUN) | (r_state == S_FIX));
    assign md.done_o  = r_done;
    assign md.hi_o    = r_hi;
    assign md.lo_o    = r_lo;
endmodule
`default_nettype wire
